// File: rtl/spi_xfer_sequencer_pkg.sv
// Shared types and constants for the SPI byte sequencer.
package spi_pkg;
  localparam int SPI_BYTE_W = 8;
  localparam int GAP_W      = 4;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_LOW,
    WAIT_HIGH,
    CAPTURE,
    GAP
  } seq_state_t;
endpackage

// File: rtl/spi_xfer_sequencer_if.sv
// Host TX/RX byte streams plus the SPI_driver handshake, bundled for the sequencer.
interface spi_xfer_sequencer_if;
  import spi_pkg::*;

  logic [SPI_BYTE_W-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [SPI_BYTE_W-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [SPI_BYTE_W-1:0] drv_data_in;
  logic                  drv_start;
  logic                  drv_en;
  logic [SPI_BYTE_W-1:0] drv_data_out;

  modport slave (
    input  tx_data, tx_valid, rx_ready, drv_en, drv_data_out,
    output tx_ready, rx_data, rx_valid, drv_data_in, drv_start
  );

  modport master (
    output tx_data, tx_valid, rx_ready, drv_en, drv_data_out,
    input  tx_ready, rx_data, rx_valid, drv_data_in, drv_start
  );
endinterface

// File: rtl/spi_xfer_sequencer_fifo.sv
// sync_fifo: flop-based FIFO, power-of-two depth, occupancy counter one bit wider than the pointers.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]                 cnt_q, cnt_d;
  logic                        do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Storage is flops, so the head read is a register mux and settles with the counter.
  assign dout    = mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/spi_xfer_sequencer.sv
// Byte-stream front end for SPI_driver: TX FIFO -> one SPI_start per byte -> RX FIFO.
// Define SPI_XFER_SEQ_RX_EN to build the RX FIFO/stream; otherwise the block is transmit-only.
module spi_xfer_sequencer
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  spi_xfer_sequencer_if.slave         bus,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] tx_level
);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  seq_state_t            state_q, state_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic                  drv_start_q, drv_start_d;
  logic [SPI_BYTE_W-1:0] drv_data_q, drv_data_d;
  logic [SPI_BYTE_W-1:0] tx_head;
  logic                  tx_full, tx_empty, tx_push, tx_pop;
  logic                  rx_push, rx_space;

  assign bus.tx_ready    = !tx_full;
  assign tx_push         = bus.tx_valid && !tx_full;
  assign bus.drv_start   = drv_start_q;
  assign bus.drv_data_in = drv_data_q;
  assign busy            = (state_q != IDLE);

  sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   (bus.tx_data),
    .pop   (tx_pop),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

`ifdef SPI_XFER_SEQ_RX_EN
  logic                       rx_full, rx_empty;
  logic [$clog2(FIFO_DEPTH):0] rx_level;
  logic                       unused_rx;

  sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .din   (bus.drv_data_out),
    .pop   (bus.rx_valid && bus.rx_ready),
    .dout  (bus.rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  assign bus.rx_valid = !rx_empty;
  // Only one byte is ever in flight, so a free RX slot at launch guarantees room at capture.
  assign rx_space     = !rx_full;
  assign unused_rx    = ^rx_level;
`else
  logic unused_rx;

  assign bus.rx_valid = 1'b0;
  assign bus.rx_data  = '0;
  assign rx_space     = 1'b1;
  assign unused_rx    = ^{bus.rx_ready, bus.drv_data_out, rx_push};
`endif

  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    drv_start_d = 1'b0;
    drv_data_d  = drv_data_q;
    tx_pop      = 1'b0;
    rx_push     = 1'b0;
    case (state_q)
      // Pop on the edge into LAUNCH so the registered start/data are both live during LAUNCH.
      IDLE: if (!tx_empty && rx_space) begin
        state_d     = LAUNCH;
        tx_pop      = 1'b1;
        drv_start_d = 1'b1;
        drv_data_d  = tx_head;
      end
      LAUNCH:    state_d = WAIT_LOW;
      WAIT_LOW:  if (!bus.drv_en) state_d = WAIT_HIGH;
      WAIT_HIGH: if (bus.drv_en)  state_d = CAPTURE;
      CAPTURE: begin
        rx_push   = 1'b1;
        gap_cnt_d = '0;
        state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
        else                       gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gap_cnt_q   <= '0;
      drv_start_q <= 1'b0;
      drv_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      drv_start_q <= drv_start_d;
      drv_data_q  <= drv_data_d;
    end
  end
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench: two sequencers (gap 2 and gap 0) each driven by a loopback SPI_driver model.
module tb_spi_xfer_sequencer;
  import spi_pkg::*;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int NREC  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]            tx_valid, tx_ready, rx_valid, rx_ready, drv_start, drv_en;
  logic [1:0]            busy;
  logic [SPI_BYTE_W-1:0] tx_data [2];
  logic [SPI_BYTE_W-1:0] rx_data [2];
  logic [SPI_BYTE_W-1:0] drv_data_in [2];
  logic [SPI_BYTE_W-1:0] drv_data_out [2];
  logic [LW-1:0]         tx_level [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spi_xfer_sequencer_if bus();
    assign bus.tx_data      = tx_data[g];
    assign bus.tx_valid     = tx_valid[g];
    assign bus.rx_ready     = rx_ready[g];
    assign bus.drv_en       = drv_en[g];
    assign bus.drv_data_out = drv_data_out[g];
    assign tx_ready[g]      = bus.tx_ready;
    assign rx_data[g]       = bus.rx_data;
    assign rx_valid[g]      = bus.rx_valid;
    assign drv_data_in[g]   = bus.drv_data_in;
    assign drv_start[g]     = bus.drv_start;

    spi_xfer_sequencer #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(g == 0 ? 2 : 0)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .busy     (busy[g]),
      .tx_level (tx_level[g])
    );
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Driver model: SPI_EN drops one edge after SPI_start, rises drv_len edges later with MISO = MOSI.
  int              drv_len [2] = '{4, 4};
  int              drv_cnt [2];
  logic [7:0]      drv_sh  [2];
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        drv_en[g]       <= 1'b1;
        drv_data_out[g] <= '0;
        drv_cnt[g]      <= 0;
      end else if (drv_cnt[g] == 0) begin
        if (drv_start[g]) begin
          drv_cnt[g] <= 1;
          drv_sh[g]  <= drv_data_in[g];
        end
      end else begin
        drv_cnt[g] <= drv_cnt[g] + 1;
        if (drv_cnt[g] == 1) drv_en[g] <= 1'b0;
        if (drv_cnt[g] == 1 + drv_len[g]) begin
          drv_en[g]       <= 1'b1;
          drv_data_out[g] <= drv_sh[g];
          drv_cnt[g]      <= 0;
        end
      end
    end
  end

  // Event recorder: start pulses, SPI_EN rises, RX handshakes.
  int         st_n [2] = '{0, 0};
  int         rs_n [2] = '{0, 0};
  int         rx_n [2] = '{0, 0};
  int         st_cyc [2][NREC];
  logic [7:0] st_dat [2][NREC];
  int         rs_cyc [2][NREC];
  logic [7:0] rx_dat [2][NREC];
  logic       en_prev [2] = '{1'b1, 1'b1};
  logic       rxv_seen [2] = '{1'b0, 1'b0};
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      en_prev[g] <= drv_en[g];
      if (drv_start[g] === 1'b1 && st_n[g] < NREC) begin
        st_cyc[g][st_n[g]] <= cyc;
        st_dat[g][st_n[g]] <= drv_data_in[g];
        st_n[g]            <= st_n[g] + 1;
      end
      if (en_prev[g] === 1'b0 && drv_en[g] === 1'b1 && rs_n[g] < NREC) begin
        rs_cyc[g][rs_n[g]] <= cyc;
        rs_n[g]            <= rs_n[g] + 1;
      end
      if (rx_valid[g] !== 1'b0) rxv_seen[g] <= 1'b1;
      if (rx_valid[g] === 1'b1 && rx_ready[g] === 1'b1 && rx_n[g] < NREC) begin
        rx_dat[g][rx_n[g]] <= rx_data[g];
        rx_n[g]            <= rx_n[g] + 1;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every action/observation happens 1 time unit after a falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(input int g, input logic [7:0] b);
    int t = 0;
    tx_data[g]  = b;
    tx_valid[g] = 1'b1;
    while (tx_ready[g] !== 1'b1 && t < 500) begin
      step(1);
      t++;
    end
    chk("push_ready", 32'(tx_ready[g]), 32'd1);
    step(1);
    tx_valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int t = 0;
    while ((busy[g] !== 1'b0 || tx_level[g] != '0) && t < 3000) begin
      step(1);
      t++;
    end
    chk("idle_wait", 32'(busy[g]), 32'd0);
  endtask

  initial begin
    int b, rb, acc, t;
    tx_valid = '0;
    rx_ready = '1;
    tx_data  = '{8'h00, 8'h00};

    // Reset values
    step(3);
    chk("rst_tx_ready", 32'(tx_ready[0]), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid[0]), 32'd0);
    chk("rst_rx_data",  32'(rx_data[0]), 32'd0);
    chk("rst_drv_data", 32'(drv_data_in[0]), 32'd0);
    chk("rst_drv_start", 32'(drv_start[0]), 32'd0);
    chk("rst_busy",     32'(busy[0]), 32'd0);
    chk("rst_tx_level", 32'(tx_level[0]), 32'd0);
    rst = 1'b0;
    step(2);
    chk("post_rst_busy", 32'(busy[1]), 32'd0);

    // Single byte: first cycle after the accept edge is IDLE, the second is LAUNCH
    b = st_n[0];
    push(0, 8'hA5);
    acc = cyc;
    wait_idle(0);
    chk("one_starts",  st_n[0] - b, 32'd1);
    chk("one_latency", st_cyc[0][b], 32'(acc + 1));
    chk("one_data",    32'(st_dat[0][b]), 32'hA5);
    chk("one_hold",    32'(drv_data_in[0]), 32'hA5);
`ifdef SPI_XFER_SEQ_RX_EN
    step(2);
    chk("one_rx_n",    32'(rx_n[0]), 32'd1);
    chk("one_rx_data", 32'(rx_dat[0][0]), 32'hA5);
`else
    chk("one_no_rx",   32'(rxv_seen[0]), 32'd0);
`endif

    // Burst filling the TX FIFO behind a slow transfer
    drv_len[0] = 20;
    b  = st_n[0];
    rb = rs_n[0];
    push(0, 8'hFF);
    step(3);
    for (int i = 1; i <= 8; i++) push(0, 8'(i));
    chk("full_level", 32'(tx_level[0]), 32'(DEPTH));
    chk("full_ready", 32'(tx_ready[0]), 32'd0);
    tx_data[0]  = 8'h99;
    tx_valid[0] = 1'b1;
    step(3);
    chk("full_hold_level", 32'(tx_level[0]), 32'(DEPTH));
    tx_valid[0] = 1'b0;
    wait_idle(0);
    chk("burst_starts", st_n[0] - b, 32'd9);
    for (int k = 0; k < 9; k++)
      chk($sformatf("burst_data%0d", k), 32'(st_dat[0][b+k]), (k == 0) ? 32'hFF : 32'(k));
    for (int k = 1; k < 9; k++)
      chk($sformatf("burst_gap%0d", k), st_cyc[0][b+k] - rs_cyc[0][rb+k-1], 32'd5);

    // RX backpressure: consumer stalled while 10 bytes are sent
    drv_len[0]  = 3;
    rx_ready[0] = 1'b0;
    b  = st_n[0];
    rb = rx_n[0];
    for (int i = 1; i <= 10; i++) push(0, 8'(i));
    step(200);
    chk("bp_busy", 32'(busy[0]), 32'd0);
`ifdef SPI_XFER_SEQ_RX_EN
    chk("bp_stall_starts", st_n[0] - b, 32'd8);
    chk("bp_tx_left",      32'(tx_level[0]), 32'd2);
    chk("bp_rx_valid",     32'(rx_valid[0]), 32'd1);
    rx_ready[0] = 1'b1;
    step(200);
    chk("bp_rx_count", rx_n[0] - rb, 32'd10);
    for (int k = 0; k < 10; k++)
      chk($sformatf("bp_rx%0d", k), 32'(rx_dat[0][rb+k]), 32'(k + 1));
`else
    chk("bp_tx_level", 32'(tx_level[0]), 32'd0);
    chk("tx_only_no_rx", 32'(rxv_seen[0]), 32'd0);
    rx_ready[0] = 1'b1;
`endif
    chk("bp_starts", st_n[0] - b, 32'd10);
    for (int k = 0; k < 10; k++)
      chk($sformatf("bp_tx%0d", k), 32'(st_dat[0][b+k]), 32'(k + 1));

    // Zero gap on the second instance
    b  = st_n[1];
    rb = rs_n[1];
    push(1, 8'h11);
    push(1, 8'h22);
    push(1, 8'h33);
    wait_idle(1);
    chk("zg_starts", st_n[1] - b, 32'd3);
    chk("zg_data2",  32'(st_dat[1][b+2]), 32'h33);
    for (int k = 1; k < 3; k++)
      chk($sformatf("zg_gap%0d", k), st_cyc[1][b+k] - rs_cyc[1][rb+k-1], 32'd3);

    // Reset while waiting for SPI_EN to rise, 3 bytes still queued
    drv_len[0] = 10;
    for (int i = 0; i < 4; i++) push(0, 8'hC1 + 8'(i));
    t = 0;
    while (drv_en[0] !== 1'b0 && t < 100) begin
      step(1);
      t++;
    end
    chk("mid_en_low", 32'(drv_en[0]), 32'd0);
    step(1);
    chk("mid_busy",  32'(busy[0]), 32'd1);
    chk("mid_level", 32'(tx_level[0]), 32'd3);
    rst = 1'b1;
    step(1);
    chk("mid_rst_busy",  32'(busy[0]), 32'd0);
    chk("mid_rst_level", 32'(tx_level[0]), 32'd0);
    chk("mid_rst_rxv",   32'(rx_valid[0]), 32'd0);
    chk("mid_rst_start", 32'(drv_start[0]), 32'd0);
    rst = 1'b0;
    step(1);
    b = st_n[0];
    step(30);
    chk("post_rst_starts", st_n[0] - b, 32'd0);
    chk("post_rst_idle",   32'(busy[0]), 32'd0);
`ifndef SPI_XFER_SEQ_RX_EN
    chk("tx_only_rx_end", 32'(rxv_seen[0] | rxv_seen[1]), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
